// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a byte stream into 16-bit words for instruction memory.
// Holds the core in reset until a frame has been loaded and its XOR checksum verified.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   start       - 1-cycle pulse that begins a new load (accepted in IDLE/DONE/ERR only)
//   byte_valid  - byte_data holds a stream byte
//   byte_data   - stream byte
//   byte_ready  - loader accepts a byte this cycle
//   imem_we     - 1-cycle write strobe to instruction memory
//   imem_addr   - write address
//   imem_wdata  - write data {high byte, low byte}
//   cpu_rst     - reset to the core, released only when a load has been verified
//   load_done   - load complete and checksum good (level)
//   load_err    - checksum mismatch or stream timeout (level)
//
// Frame: COUNT byte N (0 means 2**ADDR_W words), N (hi, lo) byte pairs, then a CHK byte.
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // One extra index bit so a full-depth load (N=0) ends at 2**ADDR_W.
  localparam int IW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    HI,
    LO,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [7:0]    checksum;
  logic [7:0]    hi_byte;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [IW-1:0] n_words;

  logic          accept;
  logic          timed_out;
  logic [IW-1:0] idx_next;
  logic [IW-1:0] count_words;

  assign accept      = byte_valid && byte_ready;
  assign timed_out   = (timer == TW'(TIMEOUT));
  assign idx_next    = idx + IW'(1);
  assign count_words = (byte_data == 8'd0) ? (IW'(1) << ADDR_W)
                                           : IW'(byte_data);

  // byte_ready is registered alongside the state, so it is high exactly
  // while the state is CNT, HI, LO or CHK; it doubles as the "loading" flag.
  always_ff @(posedge clk) begin
    imem_we <= 1'b0;
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      checksum   <= '0;
      timer      <= '0;
      idx        <= '0;
      n_words    <= '0;
      hi_byte    <= '0;
    end else if (byte_ready && timed_out) begin
      // Stall limit wins over a byte offered in the same cycle.
      state      <= ERR;
      byte_ready <= 1'b0;
      load_err   <= 1'b1;
    end else begin
      if (byte_ready) begin
        timer <= accept ? '0 : timer + TW'(1);
      end
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= CNT;
            byte_ready <= 1'b1;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            checksum   <= '0;
            timer      <= '0;
            idx        <= '0;
          end
        end
        CNT: begin
          if (accept) begin
            n_words  <= count_words;
            checksum <= checksum ^ byte_data;
            state    <= HI;
          end
        end
        HI: begin
          if (accept) begin
            hi_byte  <= byte_data;
            checksum <= checksum ^ byte_data;
            state    <= LO;
          end
        end
        LO: begin
          if (accept) begin
            checksum   <= checksum ^ byte_data;
            imem_we    <= 1'b1;
            imem_addr  <= idx[ADDR_W-1:0];
            imem_wdata <= {hi_byte, byte_data};
            idx        <= idx_next;
            state      <= (idx_next == n_words) ? CHK : HI;
          end
        end
        CHK: begin
          // The check byte itself is not folded into the checksum.
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == checksum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_rst   <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: frame-level reference model checked every cycle,
// plus literal expectations for the directed frames.
module tb_prog_loader;

  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: tracks position in the frame, not controller states.
  bit            m_on = 1'b0;
  bit            m_active, m_done, m_err, m_we;
  int            m_idle, m_pos, m_n, m_widx;
  logic [7:0]    m_sum, m_hi;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_data;

  always @(posedge clk) begin
    m_we = 1'b0;
    if (rst) begin
      m_on = 1'b1;
      m_active = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_done = 1'b0;
        m_err = 1'b0;
        m_idle = 0;
        m_pos = 0;
        m_sum = 8'h00;
        m_widx = 0;
      end
    end else if (m_idle == TO) begin
      m_active = 1'b0;
      m_err = 1'b1;
    end else if (!byte_valid) begin
      m_idle++;
    end else begin
      m_idle = 0;
      if (m_pos == 0) begin
        if (byte_data == 8'h00) m_n = 1 << AW;
        else m_n = int'(byte_data);
        m_sum ^= byte_data;
      end else if (m_pos == 2 * m_n + 1) begin
        m_active = 1'b0;
        m_done = (byte_data == m_sum);
        m_err = !m_done;
      end else if (m_pos[0]) begin
        m_hi = byte_data;
        m_sum ^= byte_data;
      end else begin
        m_sum ^= byte_data;
        m_we = 1'b1;
        m_addr = m_widx[AW-1:0];
        m_data = {m_hi, byte_data};
        m_widx++;
      end
      m_pos++;
    end
  end

  logic [AW-1:0] wr_addr[$];
  logic [15:0]   wr_data[$];

  always @(negedge clk) begin
    if (m_on) begin
      check("byte_ready", byte_ready, m_active);
      check("load_done", load_done, m_done);
      check("load_err", load_err, m_err);
      check("cpu_rst", cpu_rst, !m_done);
      check("imem_we", imem_we, m_we);
      check("imem_addr", imem_addr, m_addr);
      check("imem_wdata", imem_wdata, m_data);
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data = b;
    for (int k = 0; k <= 20; k++) begin
      if (byte_ready) begin
        tick();
        break;
      end
      if (k == 20) begin
        checks++;
        failures++;
        $display("FAIL send_wait: byte %0h not accepted in 20 cycles", b);
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  logic [7:0] fb[$];
  int gaps[6] = '{0, 3, 1, 5, 2, 4};

  task automatic send_frame(input bit gapped);
    foreach (fb[i]) send(fb[i], gapped ? gaps[i % 6] : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]  cs;
  logic [15:0] w;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", byte_ready, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_addr", imem_addr, 0);
    tick();

    // 1: two-word frame, good checksum, valid held high
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    fb = '{8'h02, 8'hF2, 8'h0A, 8'hF2, 8'h1E, 8'h16};
    send_frame(1'b0);
    check("t1_done", load_done, 1);
    check("t1_cpu_rst", cpu_rst, 0);
    check("t1_nwr", wr_addr.size(), 2);
    check("t1_a0", wr_addr[0], 8'h00);
    check("t1_d0", wr_data[0], 16'hF20A);
    check("t1_a1", wr_addr[1], 8'h01);
    check("t1_d1", wr_data[1], 16'hF21E);

    // 2: same frame, bad checksum
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    fb = '{8'h02, 8'hF2, 8'h0A, 8'hF2, 8'h1E, 8'h17};
    send_frame(1'b0);
    tick();
    check("t2_err", load_err, 1);
    check("t2_done", load_done, 0);
    check("t2_cpu_rst", cpu_rst, 1);
    check("t2_nwr", wr_addr.size(), 2);

    // 3: twelve words with valid gaps below the stall limit
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    fb.delete();
    fb.push_back(8'd12);
    cs = 8'd12;
    for (int i = 0; i < 12; i++) begin
      w = 16'(i * 16'h1111 + 16'h0305);
      fb.push_back(w[15:8]);
      fb.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    fb.push_back(cs);
    send_frame(1'b1);
    check("t3_done", load_done, 1);
    check("t3_nwr", wr_addr.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check("t3_addr", wr_addr[i], i);
      check("t3_data", wr_data[i], 16'(i * 16'h1111 + 16'h0305));
    end

    // 3b: stall after the high byte until the stall limit fires
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send(8'h03, 0);
    send(8'hAA, 0);
    repeat (12) tick();
    check("to_err", load_err, 1);
    check("to_done", load_done, 0);
    check("to_cpu_rst", cpu_rst, 1);
    check("to_nwr", wr_addr.size(), 0);

    // 4: N=0 full-depth load
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    fb.delete();
    fb.push_back(8'h00);
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i + 1)};
      fb.push_back(w[15:8]);
      fb.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    fb.push_back(cs);
    send_frame(1'b0);
    check("t4_done", load_done, 1);
    check("t4_nwr", wr_addr.size(), 256);
    check("t4_last_addr", wr_addr[255], 8'hFF);
    check("t4_last_data", wr_data[255], 16'hFF00);
    for (int i = 0; i < 256; i++) check("t4_addr", wr_addr[i], i);

    // 6: reload from DONE with a one-word frame
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check("t6_cpu_rst", cpu_rst, 1);
    check("t6_done_clr", load_done, 0);
    fb = '{8'h01, 8'hD3, 8'h00, 8'hD2};
    send_frame(1'b0);
    check("t6_done", load_done, 1);
    check("t6_nwr", wr_addr.size(), 1);
    check("t6_a0", wr_addr[0], 8'h00);
    check("t6_d0", wr_data[0], 16'hD300);

    // 5: ignored start and reset during the third word of a five-word load
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    fb = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(1'b0);
    pulse_start();
    check("t5_busy", byte_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ready", byte_ready, 0);
    check("t5_cpu_rst", cpu_rst, 1);
    check("t5_done", load_done, 0);
    check("t5_err", load_err, 0);
    check("t5_nwr", wr_addr.size(), 2);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
